// File: rtl/lottery_pkg.sv
// lottery_pkg: shared types, widths and prize table for ticket scoring.
// Used by ticket_score and pick_match.
package lottery_pkg;

    localparam int NUM_W = 6;
    localparam int SUM_W = 10;

    localparam logic [SUM_W-1:0] PRIZE_3  = 10'd5;
    localparam logic [SUM_W-1:0] PRIZE_4  = 10'd32;
    localparam logic [SUM_W-1:0] PRIZE_5  = 10'd125;
    localparam logic [SUM_W-1:0] PRIZE_5B = 10'd250;
    localparam logic [SUM_W-1:0] PRIZE_6  = 10'd750;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAW,
        ST_SCORE
    } state_e;

    // Match count (plus bonus-ball qualifier) to euro prize.
    function automatic logic [SUM_W-1:0] prize_of(
        input logic [2:0] cnt,
        input logic       bonus
    );
        logic [SUM_W-1:0] p;
        case (cnt)
            3'd3:    p = PRIZE_3;
            3'd4:    p = PRIZE_4;
            3'd5:    p = bonus ? PRIZE_5B : PRIZE_5;
            3'd6:    p = PRIZE_6;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pick_match.sv
// pick_match: compares one number against every stored pick at once.
// Only slots with en_i set can report a hit.
module pick_match
    import lottery_pkg::*;
#(
    parameter int NPICK = 6
) (
    input  logic [NUM_W-1:0]            num_i,
    input  logic [NPICK-1:0][NUM_W-1:0] picks_i,
    input  logic [NPICK-1:0]            en_i,
    output logic [NPICK-1:0]            hit_o
);

    // Parallel equality against every enabled slot.
    always_comb begin
        hit_o = '0;
        for (int i = 0; i < NPICK; i++) begin
            hit_o[i] = en_i[i] && (picks_i[i] == num_i);
        end
    end

endmodule

// File: rtl/ticket_score.sv
// ticket_score: loads picks, counts matches against drawn balls, pays out.
// Optional bonus ball: define TICKET_SCORE_BONUS_BALL_EN.
module ticket_score
    import lottery_pkg::*;
#(
    parameter int NPICK  = 6,
    parameter int MAXNUM = 49
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pick_valid,
    input  logic [NUM_W-1:0] pick,
    input  logic             ball_valid,
    input  logic [NUM_W-1:0] ball,
    output logic [SUM_W-1:0] sum,
    output logic             V,
    output logic             finish,
    output logic             busy
);

    localparam int IDX_W = $clog2(NPICK + 2);
`ifdef TICKET_SCORE_BONUS_BALL_EN
    localparam int NBALL = NPICK + 1;
    localparam logic [IDX_W-1:0] BONUS_IDX = IDX_W'(NPICK);
`else
    localparam int NBALL = NPICK;
`endif
    localparam logic [IDX_W-1:0] LAST_PICK = IDX_W'(NPICK - 1);
    localparam logic [IDX_W-1:0] LAST_BALL = IDX_W'(NBALL - 1);
    localparam logic [NUM_W-1:0] MAX_N     = NUM_W'(MAXNUM);

    state_e state_q, state_d;

    logic [NPICK-1:0][NUM_W-1:0] picks_q, picks_d;
    logic [NPICK-1:0]            hit_q, hit_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic                        ill_q, ill_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        bonus_q, bonus_d;
    logic [SUM_W-1:0]            sum_q, sum_d;
    logic                        v_q, v_d;
    logic                        fin_q, fin_d;

    logic [NUM_W-1:0] cmp_num;
    logic [NPICK-1:0] slot_en;
    logic [NPICK-1:0] match;
    logic [NPICK-1:0] fresh;

    // Comparator shared by duplicate check (LOAD) and ball match (DRAW).
    always_comb begin
        cmp_num = (state_q == ST_LOAD) ? pick : ball;
        for (int i = 0; i < NPICK; i++) begin
            slot_en[i] = (state_q == ST_DRAW) || (IDX_W'(i) < idx_q);
        end
        fresh = match & ~hit_q;
    end

    pick_match #(
        .NPICK(NPICK)
    ) u_match (
        .num_i  (cmp_num),
        .picks_i(picks_q),
        .en_i   (slot_en),
        .hit_o  (match)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (pick_valid && idx_q == LAST_PICK) state_d = ST_DRAW;
            ST_DRAW:  if (ball_valid && idx_q == LAST_BALL) state_d = ST_SCORE;
            ST_SCORE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: registered results plus busy decoded from state.
    always_comb begin
        sum    = sum_q;
        V      = v_q;
        finish = fin_q;
        busy   = (state_q != ST_IDLE);
    end

    // Datapath next-state: pick storage, hit tracking and scoring.
    always_comb begin
        picks_d = picks_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        idx_d   = idx_q;
        bonus_d = bonus_q;
        sum_d   = sum_q;
        v_d     = v_q;
        fin_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    picks_d = '0;
                    hit_d   = '0;
                    cnt_d   = '0;
                    ill_d   = 1'b0;
                    idx_d   = '0;
                    bonus_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (pick_valid) begin
                    for (int i = 0; i < NPICK; i++) begin
                        if (IDX_W'(i) == idx_q) picks_d[i] = pick;
                    end
                    if (pick == '0 || pick > MAX_N || |match) ill_d = 1'b1;
                    idx_d = (idx_q == LAST_PICK) ? '0 : idx_q + IDX_W'(1);
                end
            end
            ST_DRAW: begin
                if (ball_valid) begin
`ifdef TICKET_SCORE_BONUS_BALL_EN
                    if (idx_q == BONUS_IDX) begin
                        bonus_d = (cnt_q == 3'd5) && |fresh;
                    end else begin
                        hit_d = hit_q | fresh;
                        for (int i = 0; i < NPICK; i++) begin
                            if (fresh[i]) cnt_d = cnt_d + 3'd1;
                        end
                    end
`else
                    hit_d = hit_q | fresh;
                    for (int i = 0; i < NPICK; i++) begin
                        if (fresh[i]) cnt_d = cnt_d + 3'd1;
                    end
`endif
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_SCORE: begin
                sum_d = ill_q ? '0 : prize_of(cnt_q, bonus_q);
                v_d   = !ill_q;
                fin_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            picks_q <= '0;
            hit_q   <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            idx_q   <= '0;
            bonus_q <= 1'b0;
            sum_q   <= '0;
            v_q     <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            picks_q <= picks_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            idx_q   <= idx_d;
            bonus_q <= bonus_d;
            sum_q   <= sum_d;
            v_q     <= v_d;
            fin_q   <= fin_d;
        end
    end

endmodule

// File: tb/tb_ticket_score.sv
// tb_ticket_score: directed and random tickets against a behavioural model.
// Honours TICKET_SCORE_BONUS_BALL_EN like the design.
module tb_ticket_score;

    localparam int NPICK  = 6;
    localparam int MAXNUM = 49;
`ifdef TICKET_SCORE_BONUS_BALL_EN
    localparam int NBALL = NPICK + 1;
`else
    localparam int NBALL = NPICK;
`endif

    typedef int pick_t[NPICK];
    typedef int ball_t[NBALL];

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pick_valid;
    logic [5:0] pick;
    logic       ball_valid;
    logic [5:0] ball;
    logic [9:0] sum;
    logic       V;
    logic       finish;
    logic       busy;

    int tests = 0;
    int fails = 0;

    int e_sum  = 0;
    bit e_v    = 0;
    bit e_fin  = 0;
    bit e_busy = 0;
    bit chk_en = 0;

    ticket_score #(
        .NPICK (NPICK),
        .MAXNUM(MAXNUM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pick_valid(pick_valid),
        .pick      (pick),
        .ball_valid(ball_valid),
        .ball      (ball),
        .sum       (sum),
        .V         (V),
        .finish    (finish),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Every cycle, outputs must match the model's expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), int'(e_busy));
            chk("finish", int'(finish), int'(e_fin));
            chk("sum", int'(sum), e_sum);
            chk("V", int'(V), int'(e_v));
        end
    end

    function automatic int prize(input int m, input bit b);
        if (m == 6) return 750;
        if (m == 5) return b ? 250 : 125;
        if (m == 4) return 32;
        if (m == 3) return 5;
        return 0;
    endfunction

    // Ticket outcome straight from the rules, no notion of cycles.
    function automatic void model(input pick_t p, input ball_t b,
                                  output int s, output bit v);
        bit ill = 0;
        int m = 0;
        int unhit = -1;
        bit bon = 0;
        for (int i = 0; i < NPICK; i++) begin
            bit hit = 0;
            if (p[i] == 0 || p[i] > MAXNUM) ill = 1;
            for (int j = 0; j < i; j++) if (p[j] == p[i]) ill = 1;
            for (int k = 0; k < NPICK; k++) if (b[k] == p[i]) hit = 1;
            if (hit) m++;
            else unhit = p[i];
        end
`ifdef TICKET_SCORE_BONUS_BALL_EN
        if (m == 5 && b[NPICK] == unhit) bon = 1;
`endif
        s = ill ? 0 : prize(m, bon);
        v = !ill;
    endfunction

    function automatic ball_t mkb(input pick_t main, input int bonus);
        ball_t b;
        for (int k = 0; k < NPICK; k++) b[k] = main[k];
`ifdef TICKET_SCORE_BONUS_BALL_EN
        b[NPICK] = bonus;
`else
        if (bonus < 0) b[0] = main[0];
`endif
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        e_fin = 0;
    endtask

    task automatic gap(input int maxg, input bit in_load);
        int n = $urandom_range(maxg, 0);
        repeat (n) begin
            start = 1'($urandom_range(1, 0));
            if (in_load) begin
                ball_valid = 1'($urandom_range(1, 0));
                ball       = 6'($urandom_range(63, 0));
            end else begin
                pick_valid = 1'($urandom_range(1, 0));
                pick       = 6'($urandom_range(63, 0));
            end
            tick();
        end
        start      = 1'b0;
        pick_valid = 1'b0;
        ball_valid = 1'b0;
    endtask

    task automatic run(input pick_t p, input ball_t b, input int maxg,
                       output int s, output bit v);
        model(p, b, s, v);
        start = 1'b1;
        tick();
        start  = 1'b0;
        e_busy = 1;
        for (int i = 0; i < NPICK; i++) begin
            gap(maxg, 1);
            pick_valid = 1'b1;
            pick       = 6'(p[i]);
            tick();
            pick_valid = 1'b0;
        end
        for (int k = 0; k < NBALL; k++) begin
            gap(maxg, 0);
            ball_valid = 1'b1;
            ball       = 6'(b[k]);
            tick();
            ball_valid = 1'b0;
        end
        tick();
        e_sum  = s;
        e_v    = v;
        e_fin  = 1;
        e_busy = 0;
    endtask

    task automatic gen(output pick_t p, output ball_t b);
        int pool[49];
        int idx;
        int m;
        for (int i = 0; i < 49; i++) pool[i] = i + 1;
        for (int i = 0; i < NPICK; i++) begin
            int j = $urandom_range(48, i);
            int t = pool[i];
            pool[i] = pool[j];
            pool[j] = t;
            p[i] = pool[i];
        end
        idx = $urandom_range(NPICK - 1, 0);
        case ($urandom_range(7, 0))
            0: p[idx] = 0;
            1: p[idx] = $urandom_range(63, 50);
            2: p[idx] = p[(idx + 1) % NPICK];
            default: ;
        endcase
        if ($urandom_range(1, 0) == 1) begin
            m = $urandom_range(NPICK, 0);
            for (int k = 0; k < NPICK; k++)
                b[k] = (k < m) ? p[k] : $urandom_range(63, 50);
        end else begin
            for (int k = 0; k < NPICK; k++)
                b[k] = ($urandom_range(1, 0) == 1) ?
                       p[$urandom_range(NPICK - 1, 0)] : $urandom_range(63, 0);
        end
`ifdef TICKET_SCORE_BONUS_BALL_EN
        b[NPICK] = ($urandom_range(1, 0) == 1) ?
                   p[$urandom_range(NPICK - 1, 0)] : $urandom_range(63, 0);
`endif
    endtask

    initial begin
        pick_t p;
        ball_t b;
        int    s;
        bit    v;

        reset      = 1'b1;
        start      = 1'b0;
        pick_valid = 1'b0;
        pick       = '0;
        ball_valid = 1'b0;
        ball       = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_sum", int'(sum), 0);
        chk("rst_V", int'(V), 0);
        chk("rst_finish", int'(finish), 0);
        chk("rst_busy", int'(busy), 0);
        chk_en = 1;
        @(negedge clk);
        #2 reset = 1'b1;
        tick();

        // Full match, reversed ball order.
        p = '{1, 2, 3, 4, 5, 6};
        run(p, mkb('{6, 5, 4, 3, 2, 1}, 63), 0, s, v);
        chk("t750_model", s, 750);
        chk("t750_sum", int'(sum), 750);
        chk("t750_V", int'(V), 1);
        chk("t750_fin", int'(finish), 1);

        // Three matches; start issued during the finish cycle.
        run(p, mkb('{1, 2, 3, 40, 41, 42}, 63), 0, s, v);
        chk("t5_model", s, 5);
        chk("t5_sum", int'(sum), 5);
        chk("t5_V", int'(V), 1);

        // Repeated ball counts once.
        run(p, mkb('{1, 1, 1, 40, 41, 42}, 63), 1, s, v);
        chk("trep_model", s, 0);
        chk("trep_sum", int'(sum), 0);
        tick();

        // Duplicate pick, zero pick, out-of-range pick.
        run('{1, 2, 2, 4, 5, 6}, mkb('{1, 2, 3, 4, 5, 6}, 63), 0, s, v);
        chk("tdup_sum", int'(sum), 0);
        chk("tdup_V", int'(V), 0);
        run('{0, 2, 3, 4, 5, 6}, mkb('{1, 2, 3, 4, 5, 6}, 63), 0, s, v);
        chk("tzero_V", int'(V), 0);
        run('{50, 2, 3, 4, 5, 6}, mkb('{1, 2, 3, 4, 5, 6}, 63), 0, s, v);
        chk("t50_sum", int'(sum), 0);
        chk("t50_V", int'(V), 0);
        tick();

        // Four matches, back to back.
        p = '{10, 11, 12, 13, 14, 15};
        run(p, mkb('{10, 11, 12, 13, 30, 31}, 63), 0, s, v);
        chk("t32_model", s, 32);
        chk("t32_sum", int'(sum), 32);
        tick();
        chk("t32_fin_low", int'(finish), 0);

`ifdef TICKET_SCORE_BONUS_BALL_EN
        p = '{1, 2, 3, 4, 5, 6};
        run(p, mkb('{1, 2, 3, 4, 5, 20}, 6), 0, s, v);
        chk("tbon_model", s, 250);
        chk("tbon_sum", int'(sum), 250);
        run(p, mkb('{1, 2, 3, 4, 5, 20}, 7), 0, s, v);
        chk("tnobon_sum", int'(sum), 125);
        tick();
`endif

        // Full-match ticket so the abort below has something to clear.
        p = '{1, 2, 3, 4, 5, 6};
        run(p, mkb('{6, 5, 4, 3, 2, 1}, 63), 0, s, v);
        tick();

        // Abort after three balls.
        start = 1'b1;
        tick();
        start  = 1'b0;
        e_busy = 1;
        for (int i = 0; i < NPICK; i++) begin
            pick_valid = 1'b1;
            pick       = 6'(i + 1);
            tick();
        end
        pick_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ball_valid = 1'b1;
            ball       = 6'(k + 1);
            tick();
        end
        ball_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("abort_sum", int'(sum), 0);
        chk("abort_V", int'(V), 0);
        chk("abort_finish", int'(finish), 0);
        chk("abort_busy", int'(busy), 0);
        e_sum  = 0;
        e_v    = 0;
        e_fin  = 0;
        e_busy = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        tick();
        tick();

        // Fresh ticket after the abort.
        run(p, mkb('{1, 2, 3, 4, 40, 41}, 63), 0, s, v);
        chk("post_rst_sum", int'(sum), 32);
        chk("post_rst_V", int'(V), 1);

        // Random tickets with random idle gaps and ignored junk inputs.
        for (int t = 0; t < 150; t++) begin
            gen(p, b);
            run(p, b, 2, s, v);
            chk("rand_sum", int'(sum), s);
            if ($urandom_range(1, 0) == 1) begin
                int n = $urandom_range(3, 1);
                repeat (n) begin
                    pick_valid = 1'($urandom_range(1, 0));
                    ball_valid = 1'($urandom_range(1, 0));
                    pick       = 6'($urandom_range(63, 0));
                    ball       = 6'($urandom_range(63, 0));
                    tick();
                end
                pick_valid = 1'b0;
                ball_valid = 1'b0;
            end
        end
        tick();
        tick();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
